// File: rtl/butterfly_pipe.sv
// ---------------------------------------------------------------------------
// butterfly_pipe
//   Three-stage pipelined radix-2 complex butterfly for the FFT datapath.
//   Each beat selects DIT (out0 = A + B*W, out1 = A - B*W) or
//   DIF (out0 = A + B, out1 = (A - B)*W). An optional divide-by-2 is applied
//   to the add/subtract results. Products are rounded half-up, and every
//   result saturates, which raises a sticky overflow flag.
//
//   Stage S1: DIF pre-add/subtract, or DIT pass-through of A/B
//   Stage S2: complex multiply (B*W for DIT, (A-B)*W for DIF)
//   Stage S3: DIT post-add/subtract, or DIF pass-through (output registers)
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake (in_ready is combinational)
//   in_a, in_b, in_w      packed complex operands {re[WIDTH-1:H], im[H-1:0]}
//   in_mode               0 = DIT, 1 = DIF (travels with the beat)
//   in_scale              1 = halve the add/subtract results (travels with the beat)
//   in_tag                sideband tag, passed through unchanged
//   out_valid / out_ready output handshake
//   out0, out1, out_tag   butterfly results and the tag of the output beat
//   ovf, ovf_clr          sticky saturation flag and its synchronous clear
// ---------------------------------------------------------------------------
module butterfly_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_w,
    input  logic             in_mode,
    input  logic             in_scale,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [TAG_W-1:0] out_tag,
    output logic             ovf,
    input  logic             ovf_clr
);

    localparam int unsigned H  = WIDTH / 2;   // width of one real/imag part
    localparam int unsigned PW = 2 * H;       // full partial-product width
    localparam int unsigned CW = WIDTH + 1;   // complex result plus saturation flag

    // Saturate an (H+1)-bit signed value to H bits; MSB of result flags saturation.
    function automatic logic [H:0] sat_h(input logic [H:0] s);
        logic [H:0] r;
        r = {1'b0, s[H-1:0]};
        if (s[H] != s[H-1]) begin
            r = {1'b1, s[H], {(H-1){~s[H]}}};
        end
        return r;
    endfunction

    // Real add/subtract at H+1 bits; scaled results use (s + 1) >>> 1 and cannot overflow.
    function automatic logic [H:0] addsub_h(input logic [H-1:0] x, input logic [H-1:0] y,
                                            input logic sub, input logic scale);
        logic [H:0] xe;
        logic [H:0] ye;
        logic [H:0] s;
        logic [H:0] t;
        xe = {x[H-1], x};
        ye = {y[H-1], y};
        s  = sub ? (xe - ye) : (xe + ye);
        t  = s + (H+1)'(1);
        if (scale) begin
            return {1'b0, H'(t >> 1)};
        end
        return sat_h(s);
    endfunction

    // Q1.(H-1) real multiply: full-width product, round half-up, keep bits [2H-1:H-1].
    // Bit 2H-1 is kept so that -1 * -1 is seen as out of range and saturated.
    function automatic logic [H:0] mul_h(input logic [H-1:0] x, input logic [H-1:0] w);
        logic [PW-1:0] xe;
        logic [PW-1:0] we;
        logic [PW-1:0] p;
        xe = {{H{x[H-1]}}, x};
        we = {{H{w[H-1]}}, w};
        p  = xe * we;
        return sat_h((H+1)'((p + (PW'(1) << (H-2))) >> (H-1)));
    endfunction

    // Complex multiply; each rounded partial product is saturated before the sum.
    function automatic logic [CW-1:0] cmul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] w);
        logic [H:0] rr;
        logic [H:0] ii;
        logic [H:0] ir;
        logic [H:0] ri;
        logic [H:0] re;
        logic [H:0] im;
        rr = mul_h(x[WIDTH-1:H], w[WIDTH-1:H]);
        ii = mul_h(x[H-1:0],     w[H-1:0]);
        ir = mul_h(x[H-1:0],     w[WIDTH-1:H]);
        ri = mul_h(x[WIDTH-1:H], w[H-1:0]);
        re = sat_h({rr[H-1], rr[H-1:0]} - {ii[H-1], ii[H-1:0]});
        im = sat_h({ir[H-1], ir[H-1:0]} + {ri[H-1], ri[H-1:0]});
        return {rr[H] | ii[H] | ir[H] | ri[H] | re[H] | im[H], re[H-1:0], im[H-1:0]};
    endfunction

    // Complex add/subtract.
    function automatic logic [CW-1:0] cadd(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic sub, input logic scale);
        logic [H:0] re;
        logic [H:0] im;
        re = addsub_h(x[WIDTH-1:H], y[WIDTH-1:H], sub, scale);
        im = addsub_h(x[H-1:0],     y[H-1:0],     sub, scale);
        return {re[H] | im[H], re[H-1:0], im[H-1:0]};
    endfunction

    logic             advance;

    logic             s1_valid;
    logic             s1_mode;
    logic             s1_scale;
    logic [TAG_W-1:0] s1_tag;
    logic [WIDTH-1:0] s1_p;       // A (DIT) or A+B (DIF)
    logic [WIDTH-1:0] s1_q;       // B (DIT) or A-B (DIF): the multiplicand
    logic [WIDTH-1:0] s1_w;

    logic             s2_valid;
    logic             s2_mode;
    logic             s2_scale;
    logic [TAG_W-1:0] s2_tag;
    logic [WIDTH-1:0] s2_p;
    logic [WIDTH-1:0] s2_m;       // product

    logic [CW-1:0]    pre_sum;
    logic [CW-1:0]    pre_dif;
    logic [CW-1:0]    prod;
    logic [CW-1:0]    post_sum;
    logic [CW-1:0]    post_dif;
    logic             s1_sat;
    logic             s2_sat;
    logic             s3_sat;

    // Single global stall: the whole pipe moves only when the output slot frees.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Datapath for all three stages; saturation only counts for valid beats in the right mode.
    always_comb begin
        pre_sum  = cadd(in_a, in_b, 1'b0, in_scale);
        pre_dif  = cadd(in_a, in_b, 1'b1, in_scale);
        prod     = cmul(s1_q, s1_w);
        post_sum = cadd(s2_p, s2_m, 1'b0, s2_scale);
        post_dif = cadd(s2_p, s2_m, 1'b1, s2_scale);
        s1_sat   = in_valid &&  in_mode && (pre_sum[CW-1] || pre_dif[CW-1]);
        s2_sat   = s1_valid && prod[CW-1];
        s3_sat   = s2_valid && !s2_mode && (post_sum[CW-1] || post_dif[CW-1]);
    end

    // S1: pre-add/subtract or pass-through.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_scale <= 1'b0;
            s1_tag   <= '0;
            s1_p     <= '0;
            s1_q     <= '0;
            s1_w     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_mode  <= in_mode;
            s1_scale <= in_scale;
            s1_tag   <= in_tag;
            s1_p     <= in_mode ? pre_sum[WIDTH-1:0] : in_a;
            s1_q     <= in_mode ? pre_dif[WIDTH-1:0] : in_b;
            s1_w     <= in_w;
        end
    end

    // S2: complex multiply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_mode  <= 1'b0;
            s2_scale <= 1'b0;
            s2_tag   <= '0;
            s2_p     <= '0;
            s2_m     <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_mode  <= s1_mode;
            s2_scale <= s1_scale;
            s2_tag   <= s1_tag;
            s2_p     <= s1_p;
            s2_m     <= prod[WIDTH-1:0];
        end
    end

    // S3: post-add/subtract or pass-through into the output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out0      <= '0;
            out1      <= '0;
        end else if (advance) begin
            out_valid <= s2_valid;
            out_tag   <= s2_tag;
            out0      <= s2_mode ? s2_p : post_sum[WIDTH-1:0];
            out1      <= s2_mode ? s2_m : post_dif[WIDTH-1:0];
        end
    end

    // Sticky overflow; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf <= 1'b0;
        end else if (advance && (s1_sat || s2_sat || s3_sat)) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// ---------------------------------------------------------------------------
// tb_butterfly_pipe
//   Self-checking bench for butterfly_pipe (WIDTH = 32, TAG_W = 8): a table of
//   known vectors, hand sequences for set-vs-clear and mid-stream reset, and
//   streamed beats under random flow control checked against an integer model.
// ---------------------------------------------------------------------------
module tb_butterfly_pipe;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned TAG_W = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_w;
    logic             in_mode;
    logic             in_scale;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [TAG_W-1:0] out_tag;
    logic             ovf;
    logic             ovf_clr;

    int total = 0;
    int bad   = 0;
    logic any_sat;

    always #5 clk = ~clk;

    butterfly_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_w(in_w),
        .in_mode(in_mode), .in_scale(in_scale), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out_tag(out_tag),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic [31:0] a, b, w;
        logic        mode, scale;
        logic [7:0]  tag;
    } beat_t;

    typedef struct {
        logic [31:0] a, b, w;
        logic        mode, scale, clr;
        logic [7:0]  tag;
        logic [31:0] e0, e1;
        logic        eovf;
    } vec_t;

    typedef struct {
        logic [31:0] o0, o1;
        logic [7:0]  tag;
    } exp_t;

    typedef struct {
        int re;
        int im;
    } cpx_t;

    beat_t stim_q[$];
    vec_t  vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // ---------------- reference model: plain integer arithmetic ----------------
    function automatic int sat16(input longint v, inout bit s);
        if (v > 32767)  begin s = 1'b1; return 32767;  end
        if (v < -32768) begin s = 1'b1; return -32768; end
        return int'(v);
    endfunction

    function automatic int m_mul(input int x, input int y, inout bit s);
        longint p;
        p = longint'(x) * longint'(y);
        return sat16((p + 64'sd16384) >>> 15, s);
    endfunction

    function automatic int m_add(input int x, input int y, input bit sc, inout bit s);
        longint v;
        v = longint'(x) + longint'(y);
        if (sc) return int'((v + 64'sd1) >>> 1);
        return sat16(v, s);
    endfunction

    function automatic cpx_t unpk(input logic [31:0] v);
        cpx_t c;
        c.re = int'($signed(v[31:16]));
        c.im = int'($signed(v[15:0]));
        return c;
    endfunction

    function automatic logic [31:0] pk(input cpx_t c);
        return {16'(c.re), 16'(c.im)};
    endfunction

    function automatic cpx_t m_cadd(input cpx_t x, input cpx_t y, input bit sub, input bit sc, inout bit s);
        cpx_t r;
        r.re = m_add(x.re, sub ? -y.re : y.re, sc, s);
        r.im = m_add(x.im, sub ? -y.im : y.im, sc, s);
        return r;
    endfunction

    function automatic cpx_t m_cmul(input cpx_t x, input cpx_t w, inout bit s);
        cpx_t r;
        int rr, ii, ir, ri;
        rr = m_mul(x.re, w.re, s);
        ii = m_mul(x.im, w.im, s);
        ir = m_mul(x.im, w.re, s);
        ri = m_mul(x.re, w.im, s);
        r.re = sat16(longint'(rr) - longint'(ii), s);
        r.im = sat16(longint'(ir) + longint'(ri), s);
        return r;
    endfunction

    function automatic void model(input beat_t bt, output logic [31:0] o0, output logic [31:0] o1,
                                  output logic s);
        cpx_t a, b, w, r0, r1, t;
        bit sb;
        sb = 1'b0;
        a = unpk(bt.a);
        b = unpk(bt.b);
        w = unpk(bt.w);
        if (bt.mode == 1'b0) begin
            t  = m_cmul(b, w, sb);
            r0 = m_cadd(a, t, 1'b0, bt.scale, sb);
            r1 = m_cadd(a, t, 1'b1, bt.scale, sb);
        end else begin
            r0 = m_cadd(a, b, 1'b0, bt.scale, sb);
            t  = m_cadd(a, b, 1'b1, bt.scale, sb);
            r1 = m_cmul(t, w, sb);
        end
        o0 = pk(r0);
        o1 = pk(r1);
        s  = sb;
    endfunction

    function automatic beat_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                                 input logic mode, input logic scale, input logic [7:0] tag);
        beat_t bt;
        bt.a = a; bt.b = b; bt.w = w; bt.mode = mode; bt.scale = scale; bt.tag = tag;
        return bt;
    endfunction

    // ---------------- drivers ----------------
    task automatic pulse_clr();
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
    endtask

    // One beat into an idle pipe; returns the first output beat and the edges it took.
    task automatic send_one(input beat_t bt, input logic clr_hold,
                            output logic [31:0] g0, output logic [31:0] g1,
                            output logic [7:0] gt, output logic go, output int lat);
        in_a = bt.a; in_b = bt.b; in_w = bt.w;
        in_mode = bt.mode; in_scale = bt.scale; in_tag = bt.tag;
        in_valid = 1'b1; out_ready = 1'b1; ovf_clr = clr_hold;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        g0 = out0; g1 = out1; gt = out_tag; go = ovf;
        ovf_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    // Streams stim_q with optional random gaps and backpressure, scoreboarding every output.
    task automatic run_stream(input bit rnd, input int budget);
        exp_t        eq[$];
        exp_t        e;
        beat_t       cur;
        logic [31:0] r0, r1;
        logic        s;
        logic        stall;
        logic [31:0] p0, p1;
        logic [7:0]  pt;
        int          cyc;
        stall = 1'b0; p0 = '0; p1 = '0; pt = '0; cyc = 0;
        pulse_clr();
        any_sat = 1'b0;
        while ((stim_q.size() != 0 || eq.size() != 0) && cyc < budget) begin
            if (stim_q.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                cur = stim_q[0];
                in_valid = 1'b1;
            end else begin
                cur = mk($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 8'($urandom));
                in_valid = 1'b0;
            end
            in_a = cur.a; in_b = cur.b; in_w = cur.w;
            in_mode = cur.mode; in_scale = cur.scale; in_tag = cur.tag;
            out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            chk("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
            if (stall) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_out0", out0, p0);
                chk("hold_out1", out1, p1);
                chk("hold_tag", 32'(out_tag), 32'(pt));
            end
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got tag %h want no beat", out_tag);
                end else begin
                    e = eq.pop_front();
                    chk("stream_out0", out0, e.o0);
                    chk("stream_out1", out1, e.o1);
                    chk("stream_tag", 32'(out_tag), 32'(e.tag));
                end
            end
            if (in_valid && in_ready) begin
                model(cur, r0, r1, s);
                e.o0 = r0; e.o1 = r1; e.tag = cur.tag;
                eq.push_back(e);
                any_sat = any_sat | s;
                stim_q.delete(0);
            end
            stall = out_valid && !out_ready;
            p0 = out0; p1 = out1; pt = out_tag;
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (stim_q.size() != 0 || eq.size() != 0) begin
            bad++;
            $display("FAIL stream_drain: got %0d beats pending want 0", stim_q.size() + eq.size());
        end
        stim_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("no_dup", 32'(out_valid), 32'(0));
        chk("stream_ovf", 32'(ovf), 32'(any_sat));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] g0, g1;
        logic [7:0]  gt;
        logic        go;
        int          lat;
        beat_t       bt;

        vecs[0] = '{32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 1'b0, 8'h01,
                    32'h3000_0000, 32'hF000_0000, 1'b0};
        vecs[1] = '{32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 1'b0, 8'h02,
                    32'h7FFF_0000, 32'h0001_0000, 1'b1};
        vecs[2] = '{32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b1, 1'b0, 8'h03,
                    32'h7000_0000, 32'h0001_0000, 1'b1};
        vecs[3] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 8'h04,
                    32'h7FFF_0000, 32'h8001_0000, 1'b1};
        vecs[4] = '{32'h03E8_0000, 32'h00C8_0000, 32'h0000_7FFF, 1'b1, 1'b0, 1'b1, 8'h05,
                    32'h04B0_0000, 32'h0000_0320, 1'b0};

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
        in_a = '0; in_b = '0; in_w = '0; in_mode = 1'b0; in_scale = 1'b0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out0", out0, 32'h0);
        chk("rst_out1", out1, 32'h0);
        chk("rst_out_tag", 32'(out_tag), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_out_valid", 32'(out_valid), 32'(0));

        // Known vectors, one beat at a time through an idle pipe.
        for (int i = 0; i < 5; i++) begin
            if (vecs[i].clr) begin
                pulse_clr();
                chk("ovf_clr", 32'(ovf), 32'(0));
            end
            bt = mk(vecs[i].a, vecs[i].b, vecs[i].w, vecs[i].mode, vecs[i].scale, vecs[i].tag);
            send_one(bt, 1'b0, g0, g1, gt, go, lat);
            chk("vec_out0", g0, vecs[i].e0);
            chk("vec_out1", g1, vecs[i].e1);
            chk("vec_tag", 32'(gt), 32'(vecs[i].tag));
            chk("vec_ovf", 32'(go), 32'(vecs[i].eovf));
            chk("vec_latency", 32'(lat), 32'(3));
        end

        // Saturation and clear in the same cycle: the set must win.
        bt = mk(32'h7000_0000, 32'h7000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 8'h77);
        send_one(bt, 1'b1, g0, g1, gt, go, lat);
        chk("set_wins_ovf", 32'(go), 32'(1));
        chk("set_wins_out0", g0, 32'h7FFF_0000);
        pulse_clr();
        chk("ovf_clr_after", 32'(ovf), 32'(0));

        // Back-to-back DIT/DIF interleave.
        stim_q.push_back(mk(32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 8'h11));
        stim_q.push_back(mk(32'h03E8_0000, 32'h00C8_0000, 32'h0000_7FFF, 1'b1, 1'b0, 8'h22));
        stim_q.push_back(mk(32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 8'h33));
        stim_q.push_back(mk(32'h03E8_0000, 32'h00C8_0000, 32'h0000_7FFF, 1'b1, 1'b0, 8'h44));
        run_stream(1'b0, 50);

        // Random beats with random gaps and backpressure.
        for (int i = 0; i < 20; i++) begin
            stim_q.push_back(mk($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 8'(i + 32)));
        end
        run_stream(1'b1, 600);

        // Reset with three beats in flight.
        pulse_clr();
        in_valid = 1'b1; out_ready = 1'b1;
        in_a = 32'h7000_0000; in_b = 32'h7000_0000; in_w = 32'h7FFF_0000;
        in_mode = 1'b0; in_scale = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_tag = 8'(8'hA1 + i);
            @(posedge clk); #1;
        end
        chk("pre_rst_valid", 32'(out_valid), 32'(1));
        chk("pre_rst_tag", 32'(out_tag), 32'(8'hA1));
        chk("pre_rst_ovf", 32'(ovf), 32'(1));
        in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_ovf", 32'(ovf), 32'(0));
        chk("mid_rst_ready", 32'(in_ready), 32'(1));
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        bt = mk(32'h1000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0, 8'h5A);
        send_one(bt, 1'b0, g0, g1, gt, go, lat);
        chk("post_rst_tag", 32'(gt), 32'(8'h5A));
        chk("post_rst_latency", 32'(lat), 32'(3));
        chk("post_rst_out0", g0, 32'h3000_0000);
        chk("post_rst_out1", g1, 32'hF000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Pipelined, parametrised radix-2 complex butterfly for the FFT datapath. It supports per-beat selection of decimation-in-time (DIT) or decimation-in-frequency (DIF) structure, optional per-beat divide-by-2 scaling, round-half-up product rounding, saturation with a sticky overflow flag, and valid/ready flow control. It sits between the FFT stage sample buffer and twiddle ROM on the input side and the stage write-back on the output side. Fixed latency is 3 cycles and throughput is 1 beat per cycle.

## Interface
Parameters:
- `WIDTH`, default 32: packed complex word width; must be even. `H = WIDTH/2`. Real part is in `[WIDTH-1:H]`, imaginary part in `[H-1:0]`. Each part is signed Q1.(H-1).
- `TAG_W`, default 8: width of the sideband tag, which passes through unchanged.

Ports:
- `clk` in 1: clock; all state is updated on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block accepts the beat this cycle.
- `in_a` in WIDTH: operand A (packed complex).
- `in_b` in WIDTH: operand B (packed complex).
- `in_w` in WIDTH: twiddle W (packed complex).
- `in_mode` in 1: 0 = DIT, 1 = DIF. Travels with the beat.
- `in_scale` in 1: 1 = halve the add/subtract results. Travels with the beat.
- `in_tag` in TAG_W: sideband tag.
- `out_valid` out 1: output beat present.
- `out_ready` in 1: downstream accepts the output beat.
- `out0` out WIDTH: butterfly output 0.
- `out1` out WIDTH: butterfly output 1.
- `out_tag` out TAG_W: tag of the output beat.
- `ovf` out 1: sticky saturation flag.
- `ovf_clr` in 1: synchronous clear of `ovf`.

## Operation
- Complex multiply X·W, with each partial product computed at full 2H bits:
  - Each product is rounded by adding `1<<(H-2)`, then bits `[2H-2:H-1]` are taken.
  - If the rounded product does not fit in H bits, saturate it; this occurs only for −1·−1.
  - real = XrWr − XiWi and imag = XiWr + XrWi, each computed at H+1 bits, then saturated to H bits.
- Add/subtract ("addsub") of P ± Q:
  - Compute at H+1 bits.
  - If scale = 1: result = (s + 1) >>> 1. This always fits in H bits and never saturates.
  - If scale = 0: saturate the result to [−2^(H−1), 2^(H−1)−1].
- DIT (mode 0): `out0 = A + B·W`, `out1 = A − B·W`.
- DIF (mode 1): `out0 = A + B`, `out1 = (A − B)·W`. In DIF, scale applies to the add/subtract results, before the multiply.
- Pipeline stages:
  - S1: DIF pre-add/subtract, or DIT pass-through of A and B.
  - S2: complex multiply.
  - S3: DIT post-add/subtract, or DIF pass-through.
  - Mode, scale and tag are registered alongside the data in every stage.
- `ovf`: set whenever any saturation occurs in a beat that advances through the stage where the saturation occurs. `ovf_clr` clears it. If set and clear happen in the same cycle, set wins.
- No state machine. Control is a per-stage valid bit plus one global advance signal.

## Timing
- `advance = !out_valid || out_ready`, and `in_ready = advance` (purely combinational from `out_valid` and `out_ready`).
- A beat is accepted when `in_valid && in_ready`. It appears at the outputs with `out_valid = 1` exactly 3 advancing cycles later.
- When `advance = 0`, all stages hold: data, valid bits and tags are unchanged and no beat is lost or duplicated. `out0`, `out1` and `out_tag` stay stable while `out_valid && !out_ready`.
- Bubbles (`in_valid = 0` while advancing) propagate as valid = 0. Data registers may update freely during bubbles.
- Reset values: all stage valid bits 0, `out_valid` 0, `out0`/`out1`/`out_tag` 0, `ovf` 0, `in_ready` 1.
- Reset asserted mid-stream: all in-flight beats are discarded. After reset is released, the first output is the first beat accepted after release.
- A mode change between consecutive beats needs no gap: back-to-back DIT/DIF beats each emerge with their own mode applied.

## Test plan
Unless stated otherwise, WIDTH = 32 and scale = 0.
- DIT, A = 0x1000_0000, B = 0x2000_0000, W = 0x7FFF_0000 → out0 = 0x3000_0000, out1 = 0xF000_0000, `ovf` = 0, `out_valid` rises 3 cycles after acceptance.
- DIT saturation, A = B = 0x7000_0000, W = 0x7FFF_0000 → out0 = 0x7FFF_0000, out1 = 0x0001_0000, `ovf` = 1. With scale = 1 → out0 = 0x7000_0000, out1 = 0x0001_0000, `ovf` unchanged. Then `ovf_clr` → `ovf` = 0.
- Product corner, A = 0, B = W = 0x8000_0000, DIT → out0 = 0x7FFF_0000, out1 = 0x8001_0000, `ovf` = 1.
- DIF, A = 0x03E8_0000, B = 0x00C8_0000, W = 0x0000_7FFF → out0 = 0x04B0_0000, out1 = 0x0000_0320. Interleave with the DIT beat from the first scenario back-to-back; both results must be correct, with tags preserved and in order.
- Backpressure: stream 20 beats with random `in_valid` and `out_ready` against a reference model. Require no loss or duplication, in-order tags, and outputs stable while `out_ready` = 0.
- Assert `reset_n` = 0 with 3 beats in flight → `out_valid` = 0 and `ovf` = 0 immediately. After release, the first output carries the tag of the first beat accepted after release.
